// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - MDOp encodings, default latencies and FSM state type for the multiply/divide unit
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } mdState_t;

endpackage

// File: rtl/md_div_core.sv
// rtl/md_div_core.sv - combinational signed/unsigned 32-bit divide with sign fix-up,
// INT_MIN/-1 overflow case and divide-by-zero flag
module md_div_core (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        isSigned,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        divByZero
);

  logic        negDividend;
  logic        negDivisor;
  logic [31:0] absDividend;
  logic [31:0] absDivisor;
  logic [31:0] uQuot;
  logic [31:0] uRem;

  always_comb begin
    negDividend = isSigned & dividend[31];
    negDivisor  = isSigned & divisor[31];
    absDividend = negDividend ? (~dividend + 32'd1) : dividend;
    absDivisor  = negDivisor  ? (~divisor + 32'd1)  : divisor;
    divByZero   = (divisor == 32'd0);
    uQuot       = 32'd0;
    uRem        = 32'd0;
    if (!divByZero) begin
      uQuot = absDividend / absDivisor;
      uRem  = absDividend % absDivisor;
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign
    quot = (negDividend ^ negDivisor) ? (~uQuot + 32'd1) : uQuot;
    rem  = negDividend ? (~uRem + 32'd1) : uRem;
    if (isSigned && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit with private HI/LO and Busy stall output;
// MD_UNIT_MADD_EN enables madd/maddu/msub/msubu
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  mdState_t    state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] hiReg, hiNext;
  logic [31:0] loReg, loNext;
  logic [63:0] pend, pendNext;
  logic        pendWr, pendWrNext;

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic        [31:0] divQuot;
  logic        [31:0] divRem;
  logic               divByZero;

  assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prodU = {32'd0, A} * {32'd0, B};

  md_div_core uDivCore (
    .dividend (A),
    .divisor  (B),
    .isSigned (MDOp == MD_DIV),
    .quot     (divQuot),
    .rem      (divRem),
    .divByZero(divByZero)
  );

`ifdef MD_UNIT_MADD_EN
  logic [63:0] hiLo;
  assign hiLo = {hiReg, loReg};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= 4'd0;
      hiReg  <= 32'd0;
      loReg  <= 32'd0;
      pend   <= 64'd0;
      pendWr <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      hiReg  <= hiNext;
      loReg  <= loNext;
      pend   <= pendNext;
      pendWr <= pendWrNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    hiNext     = hiReg;
    loNext     = loReg;
    pendNext   = pend;
    pendWrNext = pendWr;
    case (state)
      MD_IDLE: begin
        if (Start) begin
          case (MDOp)
            MD_MULT: begin
              pendNext = prodS;   pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
            MD_MULTU: begin
              pendNext = prodU;   pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              // Divide by zero still occupies the full latency but never commits
              pendNext   = {divRem, divQuot};
              pendWrNext = ~divByZero;
              cntNext    = DIV_LOAD;
              stateNext  = MD_RUN;
            end
            MD_MTHI: hiNext = A;
            MD_MTLO: loNext = A;
`ifdef MD_UNIT_MADD_EN
            MD_MADD: begin
              pendNext = hiLo + prodS; pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
            MD_MADDU: begin
              pendNext = hiLo + prodU; pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
            MD_MSUB: begin
              pendNext = hiLo - prodS; pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
            MD_MSUBU: begin
              pendNext = hiLo - prodU; pendWrNext = 1'b1; cntNext = MULT_LOAD; stateNext = MD_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (cnt == 4'd0) begin
          if (pendWr) begin
            hiNext = pend[63:32];
            loNext = pend[31:0];
          end
          stateNext = MD_IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = MD_IDLE;
    endcase
  end

  assign Busy = (state == MD_RUN);
  assign HI   = hiReg;
  assign LO   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit; honours MD_UNIT_MADD_EN for the accumulate test
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = MD_NONE;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } sbEntry_t;

  sbEntry_t sb[$];
  logic [31:0] curHi = 32'd0;
  logic [31:0] curLo = 32'd0;

  md_unit dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one Start, waits out Busy, then scores HI/LO/latency
  task automatic doOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                      input int eCyc, input bit intrude);
    sbEntry_t e;
    int cnt;
    Start = 1'b1; MDOp = op; A = a; B = b;
    sb.push_back('{tag, eHi, eLo, eCyc});
    @(negedge clk);
    Start = 1'b0; MDOp = MD_NONE;
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      if (intrude && (cnt == 3 || cnt == 4)) begin
        Start = 1'b1;
        MDOp  = (cnt == 3) ? MD_MULT : MD_MTHI;
        A = 32'd3; B = 32'd3;
      end else begin
        Start = 1'b0; MDOp = MD_NONE;
      end
      @(negedge clk);
    end
    Start = 1'b0; MDOp = MD_NONE;
    e = sb.pop_front();
    checkVal({e.tag, ".cyc"}, 64'(cnt), 64'(e.cyc));
    checkVal({e.tag, ".hi"}, {32'd0, HI}, {32'd0, e.hi});
    checkVal({e.tag, ".lo"}, {32'd0, LO}, {32'd0, e.lo});
    curHi = e.hi; curLo = e.lo;
  endtask

  initial begin
    int sa, sbv;
    longint p;
    logic [63:0] pu;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    checkVal("rst.busy", {63'd0, Busy}, 64'd0);
    checkVal("rst.hilo", {HI, LO}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    doOp("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
    doOp("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0);
    doOp("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    doOp("divu",  MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10, 0);
    doOp("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);
    doOp("mthi1", MD_MTHI,  32'h0000_1234, 32'd0, 32'h0000_1234, curLo, 0, 0);
    doOp("div0",  MD_DIVU,  32'd5, 32'd0, curHi, curLo, 10, 0);
    doOp("mthi2", MD_MTHI,  32'hAAAA_5555, 32'd0, 32'hAAAA_5555, curLo, 0, 0);
    doOp("mtlo",  MD_MTLO,  32'h5A5A_0F0F, 32'd0, curHi, 32'h5A5A_0F0F, 0, 0);
    doOp("unk",   4'd15,    32'h1111_1111, 32'd9, curHi, curLo, 0, 0);
    doOp("ignore", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1);

    // Reset in cycle 3 of a multiply must clear everything and suppress the commit
    Start = 1'b1; MDOp = MD_MULT; A = 32'd7; B = 32'd9;
    @(negedge clk);
    Start = 1'b0; MDOp = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkVal("midrst.busy", {63'd0, Busy}, 64'd0);
    checkVal("midrst.hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkVal("postrst.busy", {63'd0, Busy}, 64'd0);
    checkVal("postrst.hilo", {HI, LO}, 64'd0);
    curHi = 32'd0; curLo = 32'd0;

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      sa = ra; sbv = rb;
      p = longint'(sa) * longint'(sbv);
      doOp("rmult", MD_MULT, ra, rb, p[63:32], p[31:0], 5, 0);
      pu = 64'(ra) * 64'(rb);
      doOp("rmultu", MD_MULTU, ra, rb, pu[63:32], pu[31:0], 5, 0);
      rb = $urandom_range(1, 32'h0001_0000);
      doOp("rdivu", MD_DIVU, ra, rb, ra % rb, ra / rb, 10, 0);
      sbv = (i % 2 == 0) ? -int'(rb) : int'(rb);
      doOp("rdiv", MD_DIV, ra, sbv, sa % sbv, sa / sbv, 10, 0);
    end

    doOp("setHi", MD_MTHI, 32'd0, 32'd0, 32'd0, curLo, 0, 0);
    doOp("setLo", MD_MTLO, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
`ifdef MD_UNIT_MADD_EN
    doOp("maddu", MD_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
    doOp("msub",  MD_MSUB,  32'hFFFF_FFFF, 32'd2, 32'd1, 32'd2, 5, 0);
`else
    doOp("maddu", MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0);
    doOp("msub",  MD_MSUB,  32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 0, 0);
`endif

    checkVal("sb.empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
